ad574_stream: RTL and testbench

//  Consumes the 12-bit conversion stream (data/data_valid) from the AD574 conversion
//  top level. Block-averages 2**AVG_LOG2 consecutive samples and buffers results in a

---
 rtl/ad574_stream.sv | 168 ++++++++++++++++
 tb/tb_ad574_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad574_stream.sv
// ad574_stream: block-averages the AD574 conversion stream, buffers results in a
// first-word-fall-through FIFO and presents them as an AXI4-Stream master with
// packet framing (tlast) and drop detection (sticky ovf).
// Optional feature macro: AD574_OVF_CNT_EN adds the saturating ovf_cnt port.
// Pipeline: input capture -> accumulator/result register -> FIFO write, giving
// tvalid two edges after the edge that captures the final strobe.
module ad574_stream #(
  parameter int AVG_LOG2        = 2,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PKT_LEN         = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [11:0]              data,
  input  logic                     data_valid,
  output logic [15:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef AD574_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_cnt
`endif
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [15:0] BEAT_LAST = 16'(PKT_LEN - 1);

  logic [11:0]                data_q;
  logic                       dv_q;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           sum;
  logic [CNT_W-1:0]           cnt;
  logic                       take;
  logic                       last;
  logic                       res_valid;
  logic [15:0]                res_word;
  logic [3:0]                 seq;
  logic [15:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]           level;
  logic [15:0]                beat;
  logic                       full;
  logic                       pop;
  logic                       push;
  logic                       drop;

  assign take = en && dv_q;
  assign last = take && (cnt == CNT_LAST);
  // Accumulator is wide enough for a full block of 12'hFFF samples, so no wrap.
  assign sum  = acc + ACC_W'(data_q);

  assign full = (level == LVL_FULL);
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign push = res_valid && (!full || pop);
  assign drop = res_valid && full && !pop;

  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : 16'h0000;
  assign m_axis_tlast  = m_axis_tvalid && (beat == BEAT_LAST);
  assign fifo_level    = level;

  // Capture the incoming strobe and data; en gates which strobes are kept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dv_q   <= 1'b0;
      data_q <= 12'h000;
    end else begin
      dv_q   <= data_valid && en;
      data_q <= data;
    end
  end

  // Accumulate samples; clear on block completion or whenever en is low.
  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      if (cnt == CNT_LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result stage: truncated average tagged with seq; seq advances even if later dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_word  <= 16'h0000;
      seq       <= 4'd0;
    end else begin
      res_valid <= last;
      if (last) begin
        res_word <= {seq, sum[ACC_W-1 -: 12]};
        seq      <= seq + 4'd1;
      end
    end
  end

  // FIFO storage; no reset needed since reads are gated by the level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_word;
    end
  end

  // FIFO pointers and level; a push into a full FIFO is allowed when a pop frees a slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Beat counter for packet framing; wraps after the tlast beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat <= 16'd0;
    end else if (pop) begin
      beat <= (beat == BEAT_LAST) ? 16'd0 : beat + 16'd1;
    end
  end

  // Sticky overflow flag; clear wins over a simultaneous drop.
  always_ff @(posedge clk) begin
    if (!rstn || ovf_clr) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end

`ifdef AD574_OVF_CNT_EN
  // Saturating drop counter; clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (!rstn || ovf_clr) begin
      ovf_cnt <= 16'h0000;
    end else if (drop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ad574_stream.sv
// Bench for ad574_stream (default parameters: 4-sample average, depth 16, packet 16).
module tb_ad574_stream;

  localparam int AVG_N   = 4;
  localparam int DEPTH   = 16;
  localparam int PKT_LEN = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [11:0] data = 12'h000;
  logic        data_valid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [4:0]  fifo_level;
  logic        ovf;
`ifdef AD574_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  ad574_stream dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .data         (data),
    .data_valid   (data_valid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .fifo_level   (fifo_level),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
`ifdef AD574_OVF_CNT_EN
    ,
    .ovf_cnt      (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: block in progress, next seq, expected beats in order.
  int          blk_sum = 0;
  int          blk_n = 0;
  int          seq_m = 0;
  int          model_lvl = 0;
  int          pops = 0;
  int          tlast_seen = 0;
  bit          force_keep = 0;
  bit          rand_ready = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [15:0] held;
  bit          stalled = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_sample(int d);
    logic [15:0] word;
    blk_sum += d;
    blk_n++;
    if (blk_n == AVG_N) begin
      word = {seq_m[3:0], 12'(blk_sum / AVG_N)};
      if (force_keep || model_lvl < DEPTH) begin
        exp_q.push_back(word);
        model_lvl++;
      end
      seq_m   = (seq_m + 1) % 16;
      blk_sum = 0;
      blk_n   = 0;
    end
  endtask

  task automatic sample(int d);
    data       = 12'(d);
    data_valid = 1'b1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    model_sample(d);
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic block_rand();
    for (int j = 0; j < AVG_N; j++) sample(int'($urandom_range(0, 4095)));
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    data_valid    = 1'b0;
    m_axis_tready = 1'b0;
    ovf_clr       = 1'b0;
    exp_q.delete();
    blk_sum = 0; blk_n = 0; seq_m = 0; model_lvl = 0; pops = 0; tlast_seen = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic wait_level(string tag, int n);
    int i;
    i = 0;
    while (int'(fifo_level) != n && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, 32'(fifo_level), 32'(n));
  endtask

  task automatic wait_head(string tag, logic [15:0] e);
    int i;
    i = 0;
    while (!m_axis_tvalid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, 32'(m_axis_tdata), 32'(e));
  endtask

  task automatic drain(string tag);
    int i;
    i = 0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk(tag, 32'(m_axis_tvalid), 32'd0);
  endtask

  // Beat monitor: every pop must match the model head; tdata must hold during stalls.
  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 0;
    end else begin
      if (stalled) chk("stall_hold", 32'(m_axis_tdata), 32'(held));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL extra_beat observed=%0h expected=none", m_axis_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat_data", 32'(m_axis_tdata), 32'(mon_exp));
          chk("beat_last", 32'(m_axis_tlast), 32'((pops % PKT_LEN) == PKT_LEN - 1));
        end
        if (m_axis_tlast) tlast_seen++;
        pops++;
        model_lvl--;
        stalled = 0;
      end else begin
        stalled = m_axis_tvalid;
        held    = m_axis_tdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1'b1;
    do_reset();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_level",  32'(fifo_level),    32'd0);
    chk("rst_ovf",    32'(ovf),           32'd0);
`ifdef AD574_OVF_CNT_EN
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif

    // Test 1: average of 100..103 and its latency.
    m_axis_tready = 1'b1;
    sample(100); sample(101); sample(102); sample(103);
    chk("t1_lat_k0", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_k1", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_k2", 32'(m_axis_tvalid), 32'd1);
    chk("t1_tdata",  32'(m_axis_tdata),  32'h0065);
    idle(2);
    chk("t1_popped", 32'(m_axis_tvalid), 32'd0);

    // Test 2: full-scale block and truncation.
    do_reset();
    m_axis_tready = 1'b1;
    repeat (4) sample(12'hFFF);
    wait_head("t2_fullscale", 16'h0FFF);
    idle(2);
    sample(1); sample(1); sample(1); sample(2);
    wait_head("t2_trunc", 16'h1001);
    idle(3);

    // Test 3: 17 results into a stalled depth-16 FIFO.
    do_reset();
    repeat (17) block_rand();
    idle(4);
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_ovf",   32'(ovf),        32'd1);
`ifdef AD574_OVF_CNT_EN
    chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    drain("t3_drain");
    chk("t3_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 32'd0);
`ifdef AD574_OVF_CNT_EN
    chk("t3_ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
`endif

    // Test 4: full FIFO, pop and push on the same edge.
    do_reset();
    repeat (16) block_rand();
    wait_level("t4_full", 16);
    force_keep = 1;
    block_rand();
    force_keep = 0;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    chk("t4_level", 32'(fifo_level), 32'd16);
    chk("t4_ovf",   32'(ovf),        32'd0);
    drain("t4_drain");

    // Test 5: 40 results with random backpressure; framing every 16 beats.
    do_reset();
    rand_ready = 1;
    repeat (40) block_rand();
    rand_ready = 0;
    drain("t5_drain");
    chk("t5_pops",  32'(pops),       32'd40);
    chk("t5_tlast", 32'(tlast_seen), 32'd2);
    chk("t5_ovf",   32'(ovf),        32'd0);

    // Test 6: partial block discarded by en low.
    do_reset();
    m_axis_tready = 1'b1;
    sample(50); sample(60);
    idle(2);
    en = 1'b0;
    blk_sum = 0; blk_n = 0;
    idle(3);
    en = 1'b1;
    idle(1);
    repeat (4) sample(8);
    wait_head("t6_avg", 16'h0008);
    idle(3);
    chk("t6_beats", 32'(pops), 32'd1);

    // Test 7: reset in the middle of a stream.
    m_axis_tready = 1'b0;
    repeat (3) block_rand();
    sample(77); sample(99);
    wait_level("t7_pre", 3);
    do_reset();
    chk("t7_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t7_level",  32'(fifo_level),    32'd0);
    m_axis_tready = 1'b1;
    repeat (4) sample(4);
    wait_head("t7_seq0", 16'h0004);
    idle(3);
    chk("t7_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
